bram_sdp_fifo_ctrl: RTL and testbench
=====================================

Name: bram_sdp_fifo_ctrl

Overview:
- Synchronous FIFO controller that acts as the initiator on one 18-bit half of a TDP36K block RAM used in SDP fashion: one write port and one read port.
- Converts push/pop requests into mode-correct ADDR/WDATA/WEN/REN/BE, including the 9-bit parity-on-bit-16 packing.
- Unpacks RDATA into a first-word-fall-through output stage.
- Sits between user logic and the BRAM primitive instance.

Parameters:
- DATA_WIDTH, 18, FIFO word width; legal values 1, 2, 4, 8, 9, 16, 18; any other value is an elaboration error.
- AFULL_THRESH, 0, almost-full asserts when level_o >= DEPTH-AFULL_THRESH; 0 disables it (almost_full_o tied 0).

Ports:
- CLK_i  in  1  single clock for all logic and both RAM ports
- RST_ni  in  1  asynchronous, active-low reset
- push_i  in  1  write request; accepted when push_i && !full_o
- wdata_i  in  DATA_WIDTH  write data
- full_o  out  1  level_o == DEPTH
- almost_full_o  out  1  see AFULL_THRESH
- pop_i  in  1  consume head; effective when pop_i && valid_o
- rdata_o  out  DATA_WIDTH  head word, stable while valid_o && !pop_i
- valid_o  out  1  head word present
- empty_o  out  1  level_o == 0
- level_o  out  DEPTH_LOG2+1  total words held
- MODE_o  out  3  constant mode code for the RAM configuration
- WADDR_o  out  14  RAM write address
- WDATA_o  out  18  RAM write data
- WEN_o  out  1  RAM write enable
- BE_o  out  2  RAM byte enables
- RADDR_o  out  14  RAM read address
- REN_o  out  1  RAM read enable
- RDATA_i  in  18  RAM read data, valid the cycle after REN_o is sampled

Behaviour:
- Depth per width: 1→16384, 2→8192, 4→4096, 8/9→2048, 16/18→1024.
- Address shift per width: 1→0, 2→1, 4→2, 8/9→3, 16/18→4. WADDR_o = wptr << shift, RADDR_o = rptr << shift, upper bits zero.
- MODE_o: 1→101, 2→110, 4→100, 8/9→001, 16/18→010.
- Write path is combinational from push:
  - WEN_o = push_i && !full_o; BE_o = {WEN_o, WEN_o}.
  - 9-bit: WDATA_o = {1'b0, wdata_i[8], 8'b0, wdata_i[7:0]}.
  - Other widths: WDATA_o = wdata_i zero-extended to 18 bits.
  - wptr increments on accept and wraps at DEPTH-1 → 0.
- Read unpack: 9-bit uses {RDATA_i[16], RDATA_i[7:0]}; other widths use RDATA_i[DATA_WIDTH-1:0].
- Counters:
  - ram_cnt = words written but not yet fetched.
  - loc_cnt = inflight + valid_o + skid_valid, range 0..2.
  - level_o = ram_cnt + loc_cnt.
- Prefetch rule: REN_o = (ram_cnt != 0) && (loc_cnt - pop_fire < 2). On REN_o, rptr increments (wrapping) and ram_cnt decrements; inflight is set for one cycle.
- Returning data:
  - Goes into the output register if it is free or being popped.
  - Otherwise it goes into the 1-entry skid register.
  - On pop, the skid entry moves to the output register first.
  - Ordering is strictly FIFO.
- Throughput: 1 word/cycle sustained with pop_i held high.
- Latency: push sampled at edge k → valid_o high after edge k+2 when the FIFO was empty.
- Fetch timing: data written at edge k is fetched no earlier than the cycle after k, so there is never a same-address read-during-write.
- Full/empty:
  - push while full_o: ignored, no WEN_o.
  - pop while !valid_o: ignored.
  - Simultaneous push and pop when full: pop completes, push is rejected (full_o is evaluated before the edge).
- Reset (async, any time, including mid-transfer):
  - wptr, rptr, ram_cnt, inflight, skid_valid, valid_o → 0; level_o = 0; empty_o = 1; full_o = 0; almost_full_o = 0; rdata_o = 0.
  - WEN_o = 0 and REN_o = 0 while RST_ni is low.
  - An in-flight read is discarded. RAM contents are not cleared.

Optional Feature:
- Macro: BRAM_FIFO_ERR_FLAGS_EN.
- Defined: adds outputs overflow_o and underflow_o, both sticky.
  - overflow_o sets on push_i && full_o.
  - underflow_o sets on pop_i && !valid_o.
  - Both clear only on reset.
- Undefined: the ports do not exist and there is no logic.

Decomposition:
- Package bram_fifo_pkg holds:
  - MODE code constants (MODE_1/2/4/9/18).
  - Functions depth_log2(width), addr_shift(width), mode_code(width).
  - The 14-bit RAM address and 18-bit data widths.
- One sub-module, bram_fifo_out_stage: inflight/output/skid registers and loc_cnt.

Test Plan:
- DATA_WIDTH=18: push 0x3FFFF at edge 0 → WEN_o=1, WADDR_o=0, BE_o=11; valid_o=1 with rdata_o=0x3FFFF after edge 2; level_o goes 1 then 1.
- DATA_WIDTH=9: push 0x1A5 → WDATA_o=0x100A5, WADDR_o=0; then push → WADDR_o=8; read back returns 0x1A5.
- DATA_WIDTH=16: push 1024 words (0..1023) → full_o=1; 1025th push gives no WEN_o; pop all → data 0..1023 in order, empty_o=1, level_o=0.
- Continuous push and pop at 1/cycle for 3000 words with random pop_i stalls → no loss or reordering; wptr wraps 1023→0 with WADDR_o back to 0; loc_cnt never exceeds 2.
- Assert RST_ni low with 5 words queued and REN_o in flight → valid_o=0, level_o=0, REN_o=0 immediately; after release, a new push is returned correctly with no stale data.
- With BRAM_FIFO_ERR_FLAGS_EN defined: pop on empty → underflow_o=1 and stays set; push on full → overflow_o=1; reset clears both.

Source files
------------

// File: rtl/bram_fifo_pkg.sv
// Shared constants and width-derived helpers for the BRAM SDP FIFO controller.
// RAM geometry is one 18-bit half of a TDP36K: 14-bit bit-granular address,
// 18-bit data bus.
package bram_fifo_pkg;

  localparam int RAM_ADDR_W = 14;
  localparam int RAM_DATA_W = 18;

  localparam logic [2:0] MODE_1  = 3'b101;
  localparam logic [2:0] MODE_2  = 3'b110;
  localparam logic [2:0] MODE_4  = 3'b100;
  localparam logic [2:0] MODE_9  = 3'b001;
  localparam logic [2:0] MODE_18 = 3'b010;

  function automatic bit width_legal(input int width);
    return (width == 1) || (width == 2) || (width == 4) || (width == 8) ||
           (width == 9) || (width == 16) || (width == 18);
  endfunction

  function automatic int depth_log2(input int width);
    case (width)
      1:       return 14;
      2:       return 13;
      4:       return 12;
      8, 9:    return 11;
      default: return 10;
    endcase
  endfunction

  // Word address is left-aligned into the bit-granular RAM address.
  function automatic int addr_shift(input int width);
    return RAM_ADDR_W - depth_log2(width);
  endfunction

  function automatic logic [2:0] mode_code(input int width);
    case (width)
      1:       return MODE_1;
      2:       return MODE_2;
      4:       return MODE_4;
      8, 9:    return MODE_9;
      default: return MODE_18;
    endcase
  endfunction

endpackage

// File: rtl/bram_fifo_out_stage.sv
// First-word-fall-through output stage: tracks the read in flight, holds the
// head word and a one-entry skid so a prefetched word never gets dropped.
module bram_fifo_out_stage #(
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fetch,
  input  logic [DATA_WIDTH-1:0] ram_word,
  input  logic                  pop,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            loc_cnt,
  output logic                  pop_fire
);

  logic                  inflight;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_data;

  assign pop_fire = pop && out_valid;
  assign loc_cnt  = 2'(inflight) + 2'(out_valid) + 2'(skid_valid);
  assign valid    = out_valid;
  assign data     = out_data;

  // RAM read data arrives one cycle after the fetch is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) inflight <= 1'b0;
    else        inflight <= fetch;
  end

  // Head/skid update: the older skid word always takes the head slot first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (!out_valid || pop_fire) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_data   <= skid_data;
        skid_valid <= inflight;
        if (inflight) skid_data <= ram_word;
      end else begin
        out_valid <= inflight;
        if (inflight) out_data <= ram_word;
      end
    end else if (inflight) begin
      skid_valid <= 1'b1;
      skid_data  <= ram_word;
    end
  end

endmodule

// File: rtl/bram_sdp_fifo_ctrl.sv
// Synchronous FIFO controller driving one 18-bit half of a TDP36K in SDP use.
// Optional sticky error flags (overflow_o/underflow_o) under the macro
// BRAM_FIFO_ERR_FLAGS_EN.
module bram_sdp_fifo_ctrl
  import bram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 18,
  parameter int AFULL_THRESH = 0
) (
  input  logic                              CLK_i,
  input  logic                              RST_ni,
  input  logic                              push_i,
  input  logic [DATA_WIDTH-1:0]             wdata_i,
  output logic                              full_o,
  output logic                              almost_full_o,
`ifdef BRAM_FIFO_ERR_FLAGS_EN
  output logic                              overflow_o,
  output logic                              underflow_o,
`endif
  input  logic                              pop_i,
  output logic [DATA_WIDTH-1:0]             rdata_o,
  output logic                              valid_o,
  output logic                              empty_o,
  output logic [depth_log2(DATA_WIDTH):0]   level_o,
  output logic [2:0]                        MODE_o,
  output logic [RAM_ADDR_W-1:0]             WADDR_o,
  output logic [RAM_DATA_W-1:0]             WDATA_o,
  output logic                              WEN_o,
  output logic [1:0]                        BE_o,
  output logic [RAM_ADDR_W-1:0]             RADDR_o,
  output logic                              REN_o,
  input  logic [RAM_DATA_W-1:0]             RDATA_i
);

  localparam int DEPTH_LOG2 = depth_log2(DATA_WIDTH);
  localparam int DEPTH      = 1 << DEPTH_LOG2;
  localparam int LVL_W      = DEPTH_LOG2 + 1;
  localparam int ADDR_SHIFT = addr_shift(DATA_WIDTH);

  if (!width_legal(DATA_WIDTH)) begin : g_bad_width
    $error("bram_sdp_fifo_ctrl: illegal DATA_WIDTH %0d", DATA_WIDTH);
  end

  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [DEPTH_LOG2:0]   ram_cnt;
  logic                  push_fire;
  logic                  fetch;
  logic                  pop_fire;
  logic [1:0]            loc_cnt;
  logic [DATA_WIDTH-1:0] ram_word;
  logic                  rdata_unused;

  assign rdata_unused = ^RDATA_i;

  // Reset gating keeps the RAM write port quiet while RST_ni is low.
  assign push_fire = push_i && !full_o && RST_ni;
  assign fetch     = (ram_cnt != '0) && ((loc_cnt - 2'(pop_fire)) < 2'd2);

  assign level_o = ram_cnt + LVL_W'(loc_cnt);
  assign full_o  = (level_o == LVL_W'(DEPTH));
  assign empty_o = (level_o == '0);

  if (AFULL_THRESH == 0) begin : g_no_afull
    assign almost_full_o = 1'b0;
  end else begin : g_afull
    assign almost_full_o = (level_o >= LVL_W'(DEPTH - AFULL_THRESH));
  end

  assign MODE_o  = mode_code(DATA_WIDTH);
  assign WEN_o   = push_fire;
  assign BE_o    = {2{push_fire}};
  assign WADDR_o = RAM_ADDR_W'(wptr) << ADDR_SHIFT;
  assign RADDR_o = RAM_ADDR_W'(rptr) << ADDR_SHIFT;
  assign REN_o   = fetch;

  // The 9-bit mode keeps the ninth bit in the parity lane at bit 16.
  if (DATA_WIDTH == 9) begin : g_pack9
    assign WDATA_o  = {1'b0, wdata_i[8], 8'b0, wdata_i[7:0]};
    assign ram_word = {RDATA_i[16], RDATA_i[7:0]};
  end else if (DATA_WIDTH == RAM_DATA_W) begin : g_full
    assign WDATA_o  = wdata_i;
    assign ram_word = RDATA_i;
  end else begin : g_narrow
    assign WDATA_o  = {{(RAM_DATA_W - DATA_WIDTH){1'b0}}, wdata_i};
    assign ram_word = RDATA_i[DATA_WIDTH-1:0];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_fire) wptr <= wptr + 1'b1;
      if (fetch)     rptr <= rptr + 1'b1;
    end
  end

  // Words written to the RAM but not yet fetched.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      ram_cnt <= '0;
    end else begin
      case ({push_fire, fetch})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  bram_fifo_out_stage #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_out_stage (
    .clk      (CLK_i),
    .rst_n    (RST_ni),
    .fetch    (fetch),
    .ram_word (ram_word),
    .pop      (pop_i),
    .valid    (valid_o),
    .data     (rdata_o),
    .loc_cnt  (loc_cnt),
    .pop_fire (pop_fire)
  );

`ifdef BRAM_FIFO_ERR_FLAGS_EN
  // Sticky misuse flags, cleared only by reset.
  always_ff @(posedge CLK_i or negedge RST_ni) begin
    if (!RST_ni) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (push_i && full_o)  overflow_o  <= 1'b1;
      if (pop_i && !valid_o) underflow_o <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_bram_sdp_fifo_ctrl.sv
// Self-checking bench for bram_sdp_fifo_ctrl: a 16-bit instance against a
// queue-based reference model, and a 9-bit instance for parity-lane packing.
module tb_bram_sdp_fifo_ctrl;

  localparam int DEPTH16 = 1024;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // 16-bit instance
  logic        push16, pop16;
  logic [15:0] wdata16, rdata16;
  logic        full16, afull16, valid16, empty16, wen16, ren16;
  logic [10:0] level16;
  logic [2:0]  mode16;
  logic [13:0] waddr16, raddr16;
  logic [17:0] wram16, rram16;
  logic [1:0]  be16;
`ifdef BRAM_FIFO_ERR_FLAGS_EN
  logic        ovf16, udf16, ovf9, udf9;
`endif

  // 9-bit instance
  logic        push9, pop9;
  logic [8:0]  wdata9, rdata9;
  logic        full9, afull9, valid9, empty9, wen9, ren9;
  logic [11:0] level9;
  logic [2:0]  mode9;
  logic [13:0] waddr9, raddr9;
  logic [17:0] wram9, rram9;
  logic [1:0]  be9;

  bram_sdp_fifo_ctrl #(.DATA_WIDTH(16), .AFULL_THRESH(4)) u_dut16 (
    .CLK_i(clk), .RST_ni(rst_n), .push_i(push16), .wdata_i(wdata16),
    .full_o(full16), .almost_full_o(afull16),
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    .overflow_o(ovf16), .underflow_o(udf16),
`endif
    .pop_i(pop16), .rdata_o(rdata16), .valid_o(valid16), .empty_o(empty16),
    .level_o(level16), .MODE_o(mode16), .WADDR_o(waddr16), .WDATA_o(wram16),
    .WEN_o(wen16), .BE_o(be16), .RADDR_o(raddr16), .REN_o(ren16),
    .RDATA_i(rram16)
  );

  bram_sdp_fifo_ctrl #(.DATA_WIDTH(9), .AFULL_THRESH(0)) u_dut9 (
    .CLK_i(clk), .RST_ni(rst_n), .push_i(push9), .wdata_i(wdata9),
    .full_o(full9), .almost_full_o(afull9),
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    .overflow_o(ovf9), .underflow_o(udf9),
`endif
    .pop_i(pop9), .rdata_o(rdata9), .valid_o(valid9), .empty_o(empty9),
    .level_o(level9), .MODE_o(mode9), .WADDR_o(waddr9), .WDATA_o(wram9),
    .WEN_o(wen9), .BE_o(be9), .RADDR_o(raddr9), .REN_o(ren9),
    .RDATA_i(rram9)
  );

  // Behavioural block RAMs: synchronous write, registered read.
  logic [17:0] mem16 [0:16383];
  logic [17:0] mem9  [0:16383];
  always @(posedge clk) begin
    if (wen16) mem16[waddr16] <= wram16;
    if (ren16) rram16 <= mem16[raddr16];
    if (wen9)  mem9[waddr9] <= wram9;
    if (ren9)  rram9 <= mem9[raddr9];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Reference model: every accepted word with the edge at which it was taken.
  typedef struct {
    logic [15:0] data;
    int          stamp;
  } ent_t;
  ent_t q16[$];
  int   cyc      = 0;
  int   wr_total = 0;

  // One clock of the 16-bit instance: check at negedge, advance model at posedge.
  task automatic tick16();
    logic acc, pf, exp_valid;
    @(negedge clk);
    exp_valid = 1'b0;
    if (q16.size() != 0) exp_valid = (q16[0].stamp <= cyc - 2);
    acc = push16 && rst_n && (q16.size() < DEPTH16);
    chk("level",   32'(level16), 32'(q16.size()));
    chk("empty",   32'(empty16), 32'(q16.size() == 0));
    chk("full",    32'(full16),  32'(q16.size() == DEPTH16));
    chk("afull",   32'(afull16), 32'(q16.size() >= DEPTH16 - 4));
    chk("valid",   32'(valid16), 32'(exp_valid));
    if (exp_valid) chk("rdata", 32'(rdata16), 32'(q16[0].data));
    chk("wen",     32'(wen16),   32'(acc));
    chk("be",      32'(be16),    32'({acc, acc}));
    if (acc) begin
      chk("waddr", 32'(waddr16), 32'((wr_total % DEPTH16) * 16));
      chk("wdata", 32'(wram16),  32'(wdata16));
    end
    chk("loc_le2", 32'(u_dut16.loc_cnt <= 2'd2), 32'd1);
    pf = pop16 && exp_valid;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      if (pf) void'(q16.pop_front());
      if (acc) begin
        q16.push_back('{data: wdata16, stamp: cyc});
        wr_total++;
      end
    end
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [8:0] vals9 [6];
    rst_n = 1'b0;
    push16 = 1'b0; pop16 = 1'b0; wdata16 = '0;
    push9  = 1'b0; pop9  = 1'b0; wdata9  = '0;

    // Reset state, with a push request held to confirm WEN stays low.
    repeat (2) @(posedge clk);
    #1;
    push16 = 1'b1; wdata16 = 16'hABCD;
    tick16();
    chk("rst_rdata", 32'(rdata16), 32'd0);
    chk("rst_ren",   32'(ren16),   32'd0);
    chk("mode16",    32'(mode16),  32'(3'b010));
    chk("mode9",     32'(mode9),   32'(3'b001));
    push16 = 1'b0;
    rst_n  = 1'b1;

`ifdef BRAM_FIFO_ERR_FLAGS_EN
    pop16 = 1'b1;
    tick16();
    pop16 = 1'b0;
    tick16();
    chk("underflow_set",  32'(udf16), 32'd1);
    chk("overflow_clear", 32'(ovf16), 32'd0);
`endif

    // Single word: latency and first-address behaviour.
    push16 = 1'b1; wdata16 = 16'hFFFF;
    tick16();
    push16 = 1'b0;
    repeat (4) tick16();
    pop16 = 1'b1;
    tick16();
    pop16 = 1'b0;
    tick16();

    // Fill to full, reject extra pushes, then drain in order.
    for (int i = 0; i < DEPTH16; i++) begin
      push16 = 1'b1; wdata16 = 16'(i);
      tick16();
    end
    wdata16 = 16'h5555;
    tick16();
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    chk("overflow_set",  32'(ovf16), 32'd1);
    chk("underflow_stk", 32'(udf16), 32'd1);
`endif
    pop16 = 1'b1;
    tick16();
    push16 = 1'b0;
    repeat (DEPTH16 + 6) tick16();
    pop16 = 1'b0;
    tick16();

    // Reset mid-transfer with a read in flight.
    for (int i = 0; i < 5; i++) begin
      push16 = 1'b1; wdata16 = 16'(16'hC000 + i);
      tick16();
    end
    pop16 = 1'b1;
    #2;
    chk("ren_pre_rst", 32'(ren16), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(valid16), 32'd0);
    chk("rst_level", 32'(level16), 32'd0);
    chk("rst_ren2",  32'(ren16),   32'd0);
    chk("rst_wen2",  32'(wen16),   32'd0);
    chk("rst_empty", 32'(empty16), 32'd1);
    q16.delete();
    wr_total = 0;
    tick16();
`ifdef BRAM_FIFO_ERR_FLAGS_EN
    chk("rst_ovf", 32'(ovf16), 32'd0);
    chk("rst_udf", 32'(udf16), 32'd0);
`endif
    rst_n = 1'b1;
    pop16 = 1'b0;
    push16 = 1'b1; wdata16 = 16'h1234;
    tick16();
    push16 = 1'b0;
    repeat (4) tick16();
    pop16 = 1'b1;
    repeat (3) tick16();

    // Randomized stream of 3000 words with push/pop stalls.
    begin
      int target;
      target = wr_total + 3000;
      while (wr_total < target) begin
        push16  = ($urandom_range(0, 9) < 8);
        pop16   = ($urandom_range(0, 9) < 7);
        wdata16 = 16'($urandom);
        tick16();
      end
    end
    // Sustained 1 word/cycle with both sides held high.
    pop16 = 1'b1;
    for (int i = 0; i < 200; i++) begin
      push16 = 1'b1; wdata16 = 16'($urandom);
      tick16();
    end
    push16 = 1'b0;
    repeat (q16.size() + 4) tick16();
    pop16 = 1'b0;
    tick16();

    // 9-bit packing into the parity lane and readback.
    vals9[0] = 9'h1A5;
    for (int i = 1; i < 6; i++) vals9[i] = 9'($urandom);
    for (int i = 0; i < 6; i++) begin
      push9 = 1'b1; wdata9 = vals9[i];
      @(negedge clk);
      chk("wen9",   32'(wen9),   32'd1);
      chk("waddr9", 32'(waddr9), 32'(i * 8));
      chk("wdata9", 32'(wram9),  32'({1'b0, vals9[i][8], 8'b0, vals9[i][7:0]}));
      @(posedge clk);
      #1;
    end
    push9 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      int n;
      n = 0;
      @(negedge clk);
      while (!valid9 && n < 10) begin
        @(negedge clk);
        n++;
      end
      chk("valid9", 32'(valid9), 32'd1);
      chk("rdata9", 32'(rdata9), 32'(vals9[i]));
      pop9 = 1'b1;
      @(posedge clk);
      #1;
      pop9 = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("empty9", 32'(empty9), 32'd1);
    chk("level9", 32'(level9), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
